// File: rtl/hamming_encoder.sv
// Hamming(38,32) encoder with a test-only single-bit error injector and a
// 2-entry output FIFO; counts accepted words.
module hamming_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [5:0]       err_inj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [37:0]      out_code,
    output logic [CNT_W-1:0] enc_count
);

    logic [37:0] w_data_placed;
    logic [37:0] w_enc;
    logic [37:0] w_flip;
    logic [37:0] w_code;
    logic [5:0]  w_par;
    logic        w_push;
    logic        w_pop;

    logic [37:0]      r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_enc_count;

    always_comb begin
        w_data_placed        = '0;
        w_data_placed[2]     = in_data[0];
        w_data_placed[6:4]   = in_data[3:1];
        w_data_placed[14:8]  = in_data[10:4];
        w_data_placed[30:16] = in_data[25:11];
        w_data_placed[37:32] = in_data[31:26];
    end

    // Parity slots are zero in w_data_placed, so including them in the XOR is harmless.
    always_comb begin
        w_par = '0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 38; j++) begin
                if ((((j + 1) >> k) & 1) != 0) begin
                    w_par[k] = w_par[k] ^ w_data_placed[j];
                end
            end
        end
    end

    always_comb begin
        w_enc     = w_data_placed;
        w_enc[0]  = w_par[0];
        w_enc[1]  = w_par[1];
        w_enc[3]  = w_par[2];
        w_enc[7]  = w_par[3];
        w_enc[15] = w_par[4];
        w_enc[31] = w_par[5];
    end

    assign w_flip = ((err_inj != 6'd0) && (err_inj <= 6'd38)) ? (38'd1 << (err_inj - 6'd1)) : '0;
    assign w_code = w_enc ^ w_flip;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_code  = out_valid ? r_mem[r_rptr] : '0;
    assign enc_count = r_enc_count;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_enc_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_code;
                r_wptr        <= ~r_wptr;
                r_enc_count   <= r_enc_count + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder.sv
// Randomized self-checking bench for hamming_encoder against a position-based
// Hamming reference model and a queue model of the FIFO.
module tb_hamming_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  err_inj;
    logic        out_valid;
    logic        out_ready;
    logic [37:0] out_code;
    logic [15:0] enc_count;

    logic        in4_valid;
    logic        in4_ready;
    logic [31:0] in4_data;
    logic        out4_valid;
    logic [37:0] out4_code;
    logic [3:0]  enc4_count;

    int errors = 0;
    int checks = 0;

    logic [37:0] exp_q[$];
    int          model_cnt;

    hamming_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .err_inj(err_inj), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .enc_count(enc_count)
    );

    hamming_encoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in4_valid), .in_ready(in4_ready),
        .in_data(in4_data), .err_inj(6'd0), .out_valid(out4_valid),
        .out_ready(1'b1), .out_code(out4_code), .enc_count(enc4_count)
    );

    always #5 clk = ~clk;

    // Positions are 1-based; powers of two hold parity, chosen so the syndrome is zero.
    function automatic logic [37:0] ref_encode(input logic [31:0] d, input logic [5:0] inj);
        logic [37:0] c;
        int di;
        int s;
        c  = '0;
        di = 0;
        s  = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[di];
                if (d[di]) s = s ^ pos;
                di++;
            end
        end
        for (int k = 0; k < 6; k++)
            if (((s >> k) & 1) != 0) c[(1 << k) - 1] = 1'b1;
        if (inj >= 1 && inj <= 38) c[inj-1] = ~c[inj-1];
        return c;
    endfunction

    function automatic int syndrome(input logic [37:0] c);
        int s;
        s = 0;
        for (int j = 0; j < 38; j++)
            if (c[j]) s = s ^ (j + 1);
        return s;
    endfunction

    function automatic logic [31:0] extract(input logic [37:0] c);
        logic [31:0] d;
        int di;
        d  = '0;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[di] = c[pos-1];
                di++;
            end
        end
        return d;
    endfunction

    // Advance one clock: update the model from the driven inputs, then land on the next negedge.
    task automatic tick();
        bit do_pop;
        bit do_push;
        do_pop  = (exp_q.size() > 0) && out_ready;
        do_push = in_valid && (exp_q.size() < 2);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            exp_q.push_back(ref_encode(in_data, err_inj));
            model_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        err_inj   = '0;
        in4_valid = 1'b0;
        in4_data  = '0;
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_code !== 38'h0) begin errors++; $display("FAIL reset_out_code got=%h exp=0", out_code); end
        checks++; if (enc_count !== 16'd0) begin errors++; $display("FAIL reset_enc_count got=%0d exp=0", enc_count); end
    endtask

    task automatic test_directed();
        logic [37:0] clean;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0;
        err_inj   = 6'd0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_code !== 38'h0) begin errors++; $display("FAIL zero_word got=%b/%h exp=1/0", out_valid, out_code); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        clean = out_code;
        checks++; if (syndrome(clean) != 0) begin errors++; $display("FAIL ones_syndrome got=%0d exp=0", syndrome(clean)); end
        checks++; if (extract(clean) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_data got=%h exp=ffffffff", extract(clean)); end
        checks++; if (clean !== ref_encode(32'hFFFF_FFFF, 6'd0)) begin errors++; $display("FAIL ones_code got=%h exp=%h", clean, ref_encode(32'hFFFF_FFFF, 6'd0)); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        err_inj  = 6'd5;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        err_inj  = 6'd0;
        checks++; if ((out_code ^ clean) !== 38'h10) begin errors++; $display("FAIL inj5_diff got=%h exp=10", out_code ^ clean); end
        checks++; if (syndrome(out_code) != 5) begin errors++; $display("FAIL inj5_syndrome got=%0d exp=5", syndrome(out_code)); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        err_inj  = 6'd39;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        err_inj  = 6'd0;
        checks++; if (out_code !== clean) begin errors++; $display("FAIL inj39_none got=%h exp=%h", out_code, clean); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        logic [37:0] emitted[$];
        do_reset();
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = w[0];
        tick();
        in_data = w[1];
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        in_data = w[2];
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_code !== ref_encode(w[0], 6'd0) || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_stable got=%h/%b exp=%h/0", out_code, in_ready, ref_encode(w[0], 6'd0));
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid && out_ready) emitted.push_back(out_code);
            if (exp_q.size() == 0 && model_cnt == 3) in_valid = 1'b0;
            tick();
            if (model_cnt == 3) in_valid = 1'b0;
        end
        checks++; if (emitted.size() != 3) begin errors++; $display("FAIL order_count got=%0d exp=3", emitted.size()); end
        for (int i = 0; i < 3 && i < emitted.size(); i++) begin
            checks++; if (emitted[i] !== ref_encode(w[i], 6'd0)) begin errors++; $display("FAIL order_word%0d got=%h exp=%h", i, emitted[i], ref_encode(w[i], 6'd0)); end
        end
        checks++; if (enc_count !== 16'd3) begin errors++; $display("FAIL b2b_enc_count got=%0d exp=3", enc_count); end
    endtask

    task automatic test_stream();
        int bad;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            in_data = $urandom;
            err_inj = (i % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            tick();
            if (out_valid !== 1'b1 || out_code !== exp_q[0] || in_ready !== 1'b1) bad++;
            if (err_inj == 6'd0 && syndrome(out_code) != 0) bad++;
        end
        in_valid = 1'b0;
        err_inj  = 6'd0;
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_words got=%0d_bad exp=0", bad); end
        checks++; if (enc_count !== 16'd100) begin errors++; $display("FAIL stream_enc_count got=%0d exp=100", enc_count); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_code !== 38'h0) begin errors++; $display("FAIL stream_drain got=%b/%h exp=0/0", out_valid, out_code); end
    endtask

    task automatic test_random_handshake();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            err_inj   = 6'($urandom_range(0, 63));
            tick();
            if (out_valid !== (exp_q.size() > 0)) bad++;
            if (in_ready !== (exp_q.size() < 2)) bad++;
            if (out_code !== ((exp_q.size() > 0) ? exp_q[0] : 38'h0)) bad++;
            if (enc_count !== 16'(model_cnt)) bad++;
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL random_handshake got=%0d_bad exp=0", bad); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        in4_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in4_data = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (enc4_count !== 4'd0) begin errors++; $display("FAIL cnt4_16 got=%0d exp=0", enc4_count); end
        @(posedge clk);
        @(negedge clk);
        in4_valid = 1'b0;
        checks++; if (enc4_count !== 4'd1) begin errors++; $display("FAIL cnt4_17 got=%0d exp=1", enc4_count); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] nw;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        tick();
        in_data = $urandom;
        tick();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_full got=%b/%b exp=1/0", out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_flags got=%b/%b exp=0/1", out_valid, in_ready); end
        checks++; if (enc_count !== 16'd0 || out_code !== 38'h0) begin errors++; $display("FAIL async_reset_regs got=%0d/%h exp=0/0", enc_count, out_code); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || enc_count !== 16'd0) begin errors++; $display("FAIL no_transfer_in_reset got=%b/%0d exp=0/0", out_valid, enc_count); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discarded_emitted got=%b exp=0", out_valid); end
        nw = $urandom;
        in_valid = 1'b1;
        in_data  = nw;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_code !== ref_encode(nw, 6'd0)) begin errors++; $display("FAIL resume got=%b/%h exp=1/%h", out_valid, out_code, ref_encode(nw, 6'd0)); end
        checks++; if (enc_count !== 16'd1) begin errors++; $display("FAIL resume_count got=%0d exp=1", enc_count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        err_inj   = '0;
        in4_valid = 1'b0;
        in4_data  = '0;
        model_cnt = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stream();
        test_random_handshake();
        test_count_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
